// File: rtl/bram_fifo_ctrl.sv
// bram_fifo_ctrl: runs both ports of an external SB_RAM256x16 as a
// first-word-fall-through FIFO with valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst                  single clock; synchronous active-high reset
//   in_data/in_valid/in_ready write side handshake
//   out_data/out_valid/out_ready  read side handshake (FWFT head word)
//   level                     words held: RAM + read in flight + out buffer
//   ram_we/ram_wclke/ram_waddr/ram_wdata/ram_mask  RAM write port
//   ram_re/ram_rclke/ram_raddr/ram_rdata           RAM read port
//   almost_full/almost_empty  registered level flags, present only when
//                             BRAM_FIFO_CTRL_ALMOST_EN is defined
module bram_fifo_ctrl #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 16,
   parameter int AF_THRESH  = 240,
   parameter int AE_THRESH  = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH+1:0] level,
   output logic                  ram_we,
   output logic                  ram_wclke,
   output logic [ADDR_WIDTH-1:0] ram_waddr,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   output logic [DATA_WIDTH-1:0] ram_mask,
   output logic                  ram_re,
   output logic                  ram_rclke,
   output logic [ADDR_WIDTH-1:0] ram_raddr,
   input  logic [DATA_WIDTH-1:0] ram_rdata
`ifdef BRAM_FIFO_CTRL_ALMOST_EN
   ,
   output logic                  almost_full,
   output logic                  almost_empty
`endif
);

   localparam int LW = ADDR_WIDTH + 2;
   localparam logic [ADDR_WIDTH:0] DEPTH_U = {1'b1, {ADDR_WIDTH{1'b0}}};

   logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH:0]   ram_used_q, ram_used_d;
   logic                  rd_pending_q, rd_pending_d;
   logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
   logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
   logic [1:0]            buf_count_q, buf_count_d;
   logic [LW-1:0]         level_q, level_d;

   logic       push, pop, rd;
   logic [2:0] occ, lim;

   // Handshakes and read issue. Entries committed to the buffer
   // (held + in flight) less this cycle's pop must leave room.
   always_comb begin
      in_ready  = !rst && (ram_used_q != DEPTH_U);
      push      = in_valid && in_ready;
      out_valid = !rst && (buf_count_q != 2'd0);
      pop       = out_valid && out_ready;
      occ       = {1'b0, buf_count_q} + {2'b0, rd_pending_q};
      lim       = 3'd2 + {2'b0, pop};
      rd        = !rst && (ram_used_q != '0) && (occ < lim);
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      ram_used_d   = ram_used_q;
      rd_pending_d = rd;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd)   rd_ptr_d = rd_ptr_q + 1'b1;
      if (push && !rd)      ram_used_d = ram_used_q + 1'b1;
      else if (!push && rd) ram_used_d = ram_used_q - 1'b1;

      // Output buffer: shift on pop, then land the RAM word at the tail.
      buf0_d      = buf0_q;
      buf1_d      = buf1_q;
      buf_count_d = buf_count_q;
      if (pop) begin
         buf0_d      = buf1_q;
         buf_count_d = buf_count_d - 2'd1;
      end
      if (rd_pending_q) begin
         if (buf_count_d == 2'd0) buf0_d = ram_rdata;
         else                     buf1_d = ram_rdata;
         buf_count_d = buf_count_d + 2'd1;
      end

      level_d = LW'(ram_used_d) + LW'(rd_pending_d) + LW'(buf_count_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         ram_used_q   <= '0;
         rd_pending_q <= 1'b0;
         buf0_q       <= '0;
         buf1_q       <= '0;
         buf_count_q  <= 2'd0;
         level_q      <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         ram_used_q   <= ram_used_d;
         rd_pending_q <= rd_pending_d;
         buf0_q       <= buf0_d;
         buf1_q       <= buf1_d;
         buf_count_q  <= buf_count_d;
         level_q      <= level_d;
      end
   end

   always_comb begin
      ram_we    = push;
      ram_wclke = push;
      ram_waddr = wr_ptr_q;
      ram_wdata = in_data;
      ram_mask  = '0;
      ram_re    = rd;
      ram_rclke = rd;
      ram_raddr = rd_ptr_q;
      out_data  = buf0_q;
      level     = rst ? '0 : level_q;
   end

`ifdef BRAM_FIFO_CTRL_ALMOST_EN
   logic af_q, ae_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         af_q <= 1'b0;
         ae_q <= 1'b1;
      end else begin
         af_q <= (level_d >= LW'(AF_THRESH));
         ae_q <= (level_d <= LW'(AE_THRESH));
      end
   end

   always_comb begin
      almost_full  = !rst && af_q;
      almost_empty = rst || ae_q;
   end
`else
   logic unused_thresh;
   assign unused_thresh = ^{AF_THRESH, AE_THRESH};
`endif

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// tb_bram_fifo_ctrl: directed bench for bram_fifo_ctrl with a behavioural
// SB_RAM256x16 model and an in-order scoreboard on the output side.
module tb_bram_fifo_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_data;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic [9:0]  level;
   logic        ram_we, ram_wclke, ram_re, ram_rclke;
   logic [7:0]  ram_waddr, ram_raddr;
   logic [15:0] ram_wdata, ram_mask;
   logic [15:0] ram_rdata = 16'h0;
`ifdef BRAM_FIFO_CTRL_ALMOST_EN
   logic        almost_full, almost_empty;
`endif

   bram_fifo_ctrl dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .level(level),
      .ram_we(ram_we), .ram_wclke(ram_wclke), .ram_waddr(ram_waddr),
      .ram_wdata(ram_wdata), .ram_mask(ram_mask),
      .ram_re(ram_re), .ram_rclke(ram_rclke), .ram_raddr(ram_raddr),
      .ram_rdata(ram_rdata)
`ifdef BRAM_FIFO_CTRL_ALMOST_EN
      , .almost_full(almost_full), .almost_empty(almost_empty)
`endif
   );

   always #5 clk = ~clk;

   logic [15:0] mem [256];
   always @(posedge clk) begin
      if (ram_we && ram_wclke) mem[ram_waddr] <= ram_wdata;
      if (ram_re && ram_rclke) ram_rdata <= mem[ram_raddr];
   end

   int errs = 0;
   int checks = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic look();
      @(negedge clk);
   endtask

   logic [15:0] exp_q[$];
   int          coll = 0;
   int          mask_bad = 0;
   logic        stall_v = 1'b0;
   logic [15:0] stall_d = 16'h0;

   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         stall_v = 1'b0;
      end else begin
         if (ram_mask != 16'h0) mask_bad++;
         if (ram_we && ram_re && ram_waddr == ram_raddr) coll++;
         if (stall_v) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_data", 32'(out_data), 32'(stall_d));
         end
         stall_v = out_valid && !out_ready;
         stall_d = out_data;
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0)
               chk("pop_when_empty", 32'(exp_q.size()), 32'd1);
            else
               chk("data_order", 32'(out_data), 32'(exp_q.pop_front()));
         end
         if (in_valid && in_ready) exp_q.push_back(in_data);
      end
   end

   task automatic do_reset();
      tick();
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   task automatic drain();
      int b;
      in_valid = 1'b0;
      out_ready = 1'b1;
      b = 0;
      look();
      while (!(level == 10'd0 && !out_valid) && b < 600) begin
         tick();
         look();
         b++;
      end
      chk("drain_empty", 32'(level), 32'd0);
      tick();
      out_ready = 1'b0;
   endtask

   initial begin
      #2000000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end

   initial begin
      int acc, bud, wraps, pops, sent;
      logic have;
      logic [7:0] pwa;
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

      rst = 1'b1; in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b0;
      tick();
      look();
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_level", 32'(level), 32'd0);
      chk("rst_we", 32'(ram_we), 32'd0);
      chk("rst_re", 32'(ram_re), 32'd0);
      tick();
      rst = 1'b0;
      look();
      chk("post_rst_level", 32'(level), 32'd0);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // latency from empty
      tick();
      in_valid = 1'b1; in_data = 16'hBEEF;
      look();
      chk("lat_we", 32'(ram_we), 32'd1);
      chk("lat_waddr", 32'(ram_waddr), 32'h00);
      tick();
      in_valid = 1'b0;
      look();
      chk("lat_re_t1", 32'(ram_re), 32'd1);
      chk("lat_raddr_t1", 32'(ram_raddr), 32'h00);
      chk("lat_level_t1", 32'(level), 32'd1);
      chk("lat_valid_t1", 32'(out_valid), 32'd0);
      tick();
      look();
      chk("lat_valid_t2", 32'(out_valid), 32'd0);
      tick();
      look();
      chk("lat_valid_t3", 32'(out_valid), 32'd1);
      chk("lat_data_t3", 32'(out_data), 32'hBEEF);
      chk("lat_level_t3", 32'(level), 32'd1);
      tick();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      look();
      chk("lat_after_pop", 32'(level), 32'd0);

      // fill to full
      do_reset();
      acc = 0; bud = 0; wraps = 0; have = 1'b0; pwa = 8'h0;
      in_valid = 1'b1; in_data = 16'h0;
      while (acc < 258 && bud < 400) begin
         look();
         bud++;
         if (in_valid && in_ready) begin
            if (have && pwa == 8'hFF && ram_waddr == 8'h00) wraps++;
            pwa = ram_waddr;
            have = 1'b1;
            acc++;
         end
         tick();
         in_data = 16'(acc);
      end
      look();
      chk("full_accepts", 32'(acc), 32'd258);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      chk("full_we", 32'(ram_we), 32'd0);
      chk("full_level", 32'(level), 32'd258);
      chk("full_wraps", 32'(wraps), 32'd1);
      tick();
      drain();

      // streaming
      do_reset();
      in_valid = 1'b1; out_ready = 1'b1; in_data = 16'h0;
      sent = 0; pops = 0;
      for (int i = 0; i < 1000; i++) begin
         look();
         if (in_ready) sent++;
         if (out_valid) pops++;
         if (i == 999) chk("stream_level", 32'(level), 32'd3);
         tick();
         in_data = 16'(sent);
      end
      chk("stream_sent", 32'(sent), 32'd1000);
      chk("stream_pops", 32'(pops), 32'd997);
      drain();

      // backpressure
      do_reset();
      in_valid = 1'b1; sent = 0; pops = 0;
      for (int i = 0; i < 40; i++) begin
         out_ready = pat[i % 4];
         in_data = 16'h5000 + 16'(sent);
         look();
         if (in_ready) sent++;
         if (out_valid && out_ready) pops++;
         tick();
      end
      chk("bp_sent", 32'(sent), 32'd40);
      chk("bp_pops", 32'(pops), 32'd19);
      drain();

      // reset mid-stream
      do_reset();
      in_valid = 1'b1; out_ready = 1'b0; acc = 0; bud = 0;
      in_data = 16'h0100;
      while (acc < 37 && bud < 100) begin
         look();
         bud++;
         if (in_ready) acc++;
         tick();
         in_data = 16'h0100 + 16'(acc);
      end
      out_ready = 1'b1;
      look();
      chk("mid_re_issued", 32'(ram_re), 32'd1);
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      look();
      chk("mid_level", 32'(level), 32'd37);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      look();
      chk("mid_rst_level", 32'(level), 32'd0);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      tick();
      in_valid = 1'b1; in_data = 16'h1234;
      look();
      chk("mid_waddr", 32'(ram_waddr), 32'h00);
      tick();
      in_valid = 1'b0;
      look();
      chk("mid_re", 32'(ram_re), 32'd1);
      chk("mid_raddr", 32'(ram_raddr), 32'h00);
      tick();
      tick();
      look();
      chk("mid_out_data", 32'(out_data), 32'h1234);
      tick();
      drain();

`ifdef BRAM_FIFO_CTRL_ALMOST_EN
      do_reset();
      acc = 0;
      out_ready = 1'b0;
      for (int i = 0; i < 245; i++) begin
         in_valid = (acc < 240);
         in_data = 16'h7000 + 16'(acc);
         look();
         chk("al_level", 32'(level), 32'(acc));
         chk("al_full", 32'(almost_full), 32'(acc >= 240));
         chk("al_empty", 32'(almost_empty), 32'(acc <= 2));
         if (in_valid && in_ready) acc++;
         tick();
      end
      drain();
`endif

      chk("no_same_addr_rw", 32'(coll), 32'd0);
      chk("mask_zero", 32'(mask_bad), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule

// File: doc/bram_fifo_ctrl.md
Name: bram_fifo_ctrl

Overview:
- Controller that owns both ports of an external SB_RAM256x16 block and presents it as a first-word-fall-through FIFO with valid/ready handshakes on both sides.
- It drives WE/WCLKE/WADDR/WDATA/MASK and RE/RCLKE/RADDR, and consumes the registered RDATA.
- Used as the streaming buffer in front of and behind BRAM-backed datapaths; the RAM primitive is instantiated next to it in the same netlist.

Parameters:
ADDR_WIDTH, 8, RAM address width; RAM depth DEPTH = 2**ADDR_WIDTH
DATA_WIDTH, 16, word width; equals the RAM data/mask width
AF_THRESH, 240, almost_full threshold on level (used only with the optional feature)
AE_THRESH, 2, almost_empty threshold on level (used only with the optional feature)

Ports:
clk  in  1  single clock for the block, RAM WCLK and RAM RCLK
rst  in  1  synchronous, active-high reset
in_data  in  DATA_WIDTH  write word
in_valid  in  1  producer has a word
in_ready  out  1  block accepts a word this cycle
out_data  out  DATA_WIDTH  head-of-FIFO word
out_valid  out  1  out_data valid
out_ready  in  1  consumer takes the word
level  out  ADDR_WIDTH+2  total words held (RAM + in flight + output buffer)
ram_we  out  1  RAM WE
ram_wclke  out  1  RAM WCLKE
ram_waddr  out  ADDR_WIDTH  RAM WADDR
ram_wdata  out  DATA_WIDTH  RAM WDATA
ram_mask  out  DATA_WIDTH  RAM MASK; a 1 bit blocks the write of that bit; always 0
ram_re  out  1  RAM RE
ram_rclke  out  1  RAM RCLKE
ram_raddr  out  ADDR_WIDTH  RAM RADDR
ram_rdata  in  DATA_WIDTH  RAM RDATA, valid the cycle after ram_re

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset, while rst is high and on the first cycle after it:
  - wr_ptr = rd_ptr = 0; ram_used = 0; rd_pending = 0; 2-entry output buffer empty.
  - Outputs: out_valid = 0, level = 0, ram_we = ram_wclke = ram_re = ram_rclke = 0, ram_mask = 0.
  - in_ready = 0 while rst is high.
  - RAM contents are not cleared.
- Reset mid-operation: any in-flight read is discarded, and buffered words are dropped.
- Write side:
  - in_ready = !rst && (ram_used != DEPTH).
  - push = in_valid && in_ready. On push, ram_we = ram_wclke = 1, ram_waddr = wr_ptr, ram_wdata = in_data, and wr_ptr increments modulo DEPTH.
  - Other cycles: ram_we = ram_wclke = 0.
- Read side:
  - pop = out_valid && out_ready.
  - The read issue signal rd is true when ram_used > 0 and (buf_count + rd_pending − pop) < 2.
  - On rd: ram_re = ram_rclke = 1, ram_raddr = rd_ptr, rd_ptr increments modulo DEPTH, and rd_pending is set for the next cycle.
  - When rd_pending is set, ram_rdata is written into the output buffer tail at the end of that cycle.
- ram_used:
  - Next value = ram_used + push − rd.
  - A word pushed in cycle t is readable from cycle t+1 onward, so the same address is never read and written in one cycle.
- Output buffer:
  - 2-entry FIFO of registers; out_data is the head entry and out_valid = (buf_count != 0).
  - A simultaneous pop and load in the same cycle is legal.
- Throughput and latency:
  - Sustains 1 word/cycle in each direction.
  - From an empty FIFO, a word accepted in cycle t gives out_valid = 1 in cycle t+3.
- level:
  - Equals ram_used + rd_pending + buf_count; it is registered and updated every cycle.
  - Maximum value is DEPTH+2.
- Full: in_ready = 0 while ram_used = DEPTH; push is ignored if in_valid is asserted then.
- Empty: no ram_re is issued and out_valid = 0; out_ready has no effect.
- Pointer wrap: after address DEPTH−1 the next address is 0, with no bubble.
- Simultaneous push and rd while ram_used = DEPTH: not possible, because in_ready is already 0.
- out_data and out_valid hold steady while out_valid = 1 and out_ready = 0.

Optional Feature:
- Macro: BRAM_FIFO_CTRL_ALMOST_EN.
- When defined, adds outputs almost_full (1 bit) and almost_empty (1 bit), both registered.
  - almost_full = (level >= AF_THRESH).
  - almost_empty = (level <= AE_THRESH).
  - Both are 0 in reset except almost_empty, which is 1.
- When not defined, neither port exists and AF_THRESH/AE_THRESH are unused.

Test Plan:
- Fill to full: after reset, push 0x0000..0x0101 (258 words) with out_ready = 0. Expect in_ready to drop after 258 accepts, level = 258, and ram_waddr to wrap 0xFF→0x00 exactly once.
- Latency: from empty, push 0xBEEF in cycle t. Expect ram_re at t+1 with raddr 0x00, out_valid at t+3 with out_data 0xBEEF, and level = 1 from t+1.
- Streaming: in_valid = out_ready = 1 for 1000 cycles with an incrementing pattern. Expect one word/cycle after the initial 3-cycle fill, data in order, and no ram_we/ram_re to the same address in any cycle.
- Backpressure: toggle out_ready 1,0,0,1 while pushing continuously. Expect out_data stable while stalled, no loss or duplication, and ram_mask = 0 throughout.
- Reset mid-stream: assert rst for one cycle with level = 37 and a read in flight. Expect level = 0, out_valid = 0 next cycle, and the next pushed word 0x1234 to appear at raddr 0x00.
- With BRAM_FIFO_CTRL_ALMOST_EN defined: push 240 words. Expect almost_full to rise when level reaches 240 and almost_empty to be 1 only while level ≤ 2.
